// File: rtl/cap_pad_emulator_pkg.sv
// Shared types and defaults for the capacitive pad emulator.
// Latency: n/a (types, constants and a pure saturating-clip helper only).
// Backpressure: n/a.
// Contents: FSM state enum, default parameter values, LFSR seed/taps, cap_sat().
package cap_touch_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    CHARGING = 2'd1,
    FULL     = 2'd2,
    DECAY    = 2'd3
  } cap_pad_state_t;

  localparam int unsigned CAP_CNT_W         = 8;
  localparam int unsigned CAP_CHARGE_CYCLES = 4;
  localparam int unsigned CAP_BASE_DECAY    = 20;
  localparam int unsigned CAP_TOUCH_EXTRA   = 40;

  // Galois right-shift form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] CAP_LFSR_SEED = 8'hA5;
  localparam logic [7:0] CAP_LFSR_TAPS = 8'hB8;

  // Clip a decay-length sum to the largest value the counters can hold.
  function automatic logic [31:0] cap_sat(input logic [31:0] sum, input logic [31:0] max_val);
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/cap_pad_emulator_if.sv
// Pin-level bundle between the touch sensor and the pad emulator.
// Latency: n/a (wires only).
// Backpressure: none; the sensor side owns drive/oe/touch, the emulator owns the rest.
// master = sensor side, slave = emulator side.
interface cap_pad_emulator_if #(
  parameter int unsigned CNT_W = 8
);
  logic             pad_drive;
  logic             pad_oe;
  logic             touch_in;
  logic             pad_level;
  logic             decay_done;
  logic [CNT_W-1:0] last_decay;

  modport master (
    output pad_drive, pad_oe, touch_in,
    input  pad_level, decay_done, last_decay
  );

  modport slave (
    input  pad_drive, pad_oe, touch_in,
    output pad_level, decay_done, last_decay
  );
endinterface

// File: rtl/cap_pad_emulator_lfsr.sv
// Free-running 8-bit Galois LFSR supplying 0..3 cycles of decay jitter.
// Latency: advances every clk; jitter reflects the current register state.
// Backpressure: none.
// Ports: clk, rst_n (async, active-low, reloads seed), jitter[1:0].
// Only instantiated when CAP_PAD_JITTER_EN is defined.
module cap_pad_lfsr
  import cap_touch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] jitter
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ CAP_LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= CAP_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign jitter = lfsr_q[1:0];

endmodule

// File: rtl/cap_pad_emulator.sv
// Capacitive touch pad model answering a sensor's charge/release/decay-timing cycle.
// Latency: pad_level rises CHARGE_CYCLES edges after first driven-high cycle; decay lasts target edges.
// Backpressure: none; the pin bundle is sampled every cycle and all outputs are registered.
// Ports: clk, rst_n (async, active-low); pad_if (slave): pad_drive, pad_oe, touch_in in;
//        pad_level, decay_done, last_decay out.
// Optional: define CAP_PAD_JITTER_EN to add 0..3 cycles of LFSR jitter to each decay target.
module cap_pad_emulator
  import cap_touch_pkg::*;
#(
  parameter int unsigned CNT_W         = CAP_CNT_W,
  parameter int unsigned CHARGE_CYCLES = CAP_CHARGE_CYCLES,
  parameter int unsigned BASE_DECAY    = CAP_BASE_DECAY,
  parameter int unsigned TOUCH_EXTRA   = CAP_TOUCH_EXTRA
) (
  input  logic                clk,
  input  logic                rst_n,
  cap_pad_emulator_if.slave   pad_if
);

  localparam logic [31:0]      CNT_MAX     = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);

  cap_pad_state_t   state_q, state_d;
  logic [CNT_W-1:0] charge_q, charge_d;
  logic [CNT_W-1:0] decay_q, decay_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             level_q, level_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] last_q, last_d;

  logic [31:0]      jitter32;
  logic [31:0]      rel_sum;
  logic [CNT_W-1:0] rel_target;

`ifdef CAP_PAD_JITTER_EN
  logic [1:0] jitter;
  cap_pad_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .jitter (jitter)
  );
  assign jitter32 = {30'd0, jitter};
`else
  assign jitter32 = 32'd0;
`endif

  // Decay length is fixed at the release edge; later touch_in changes are ignored.
  assign rel_sum    = 32'(BASE_DECAY) + (pad_if.touch_in ? 32'(TOUCH_EXTRA) : 32'd0) + jitter32;
  assign rel_target = CNT_W'(cap_sat(rel_sum, CNT_MAX));

  always_comb begin
    state_d  = state_q;
    charge_d = charge_q;
    decay_d  = decay_q;
    target_d = target_q;
    level_d  = level_q;
    done_d   = 1'b0;
    last_d   = last_q;

    if (pad_if.pad_oe && !pad_if.pad_drive) begin
      // Sensor actively pulling low wins from every state.
      state_d  = EMPTY;
      level_d  = 1'b0;
      charge_d = '0;
      decay_d  = '0;
      target_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (pad_if.pad_oe) begin
            if (CHARGE_CYCLES <= 1) begin
              state_d = FULL;
              level_d = 1'b1;
            end else begin
              // This edge is the first charged cycle.
              state_d  = CHARGING;
              charge_d = CNT_W'(1);
            end
          end
        end
        CHARGING: begin
          if (!pad_if.pad_oe) begin
            state_d  = EMPTY;
            charge_d = '0;
          end else if (charge_q == CHARGE_LAST) begin
            state_d  = FULL;
            level_d  = 1'b1;
            charge_d = '0;
          end else begin
            charge_d = charge_q + 1'b1;
          end
        end
        FULL: begin
          if (!pad_if.pad_oe) begin
            if (rel_target == '0) begin
              // Zero-length decay completes on the release edge itself.
              state_d = EMPTY;
              level_d = 1'b0;
              done_d  = 1'b1;
              last_d  = '0;
            end else begin
              state_d  = DECAY;
              target_d = rel_target;
              decay_d  = CNT_W'(1);
            end
          end
        end
        DECAY: begin
          if (pad_if.pad_oe) begin
            // Re-driven high while still charged: back to FULL, no completion.
            state_d  = FULL;
            level_d  = 1'b1;
            decay_d  = '0;
            target_d = '0;
          end else if (decay_q == target_q) begin
            state_d  = EMPTY;
            level_d  = 1'b0;
            done_d   = 1'b1;
            last_d   = target_q;
            decay_d  = '0;
            target_d = '0;
          end else begin
            decay_d = decay_q + 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
          level_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      charge_q <= '0;
      decay_q  <= '0;
      target_q <= '0;
      level_q  <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      charge_q <= charge_d;
      decay_q  <= decay_d;
      target_q <= target_d;
      level_q  <= level_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  assign pad_if.pad_level  = level_q;
  assign pad_if.decay_done = done_q;
  assign pad_if.last_decay = last_q;

endmodule

// File: tb/tb_cap_pad_emulator.sv
// Directed bench for cap_pad_emulator: default instance plus a 6-bit saturating instance.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_cap_pad_emulator;
  import cap_touch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done1 = 0;
  int   done2 = 0;
  int   d0;

  always #5 clk = ~clk;

  cap_pad_emulator_if #(.CNT_W(8)) if1 ();
  cap_pad_emulator_if #(.CNT_W(6)) if2 ();

  cap_pad_emulator #(
    .CNT_W(8), .CHARGE_CYCLES(4), .BASE_DECAY(20), .TOUCH_EXTRA(40)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_if (if1)
  );

  cap_pad_emulator #(
    .CNT_W(6), .CHARGE_CYCLES(4), .BASE_DECAY(40), .TOUCH_EXTRA(40)
  ) u_dut_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_if (if2)
  );

  always @(negedge clk) begin
    if (if1.decay_done === 1'b1) done1++;
    if (if2.decay_done === 1'b1) done2++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if1.pad_oe = 1'b0; if1.pad_drive = 1'b0; if1.touch_in = 1'b0;
    if2.pad_oe = 1'b0; if2.pad_drive = 1'b0; if2.touch_in = 1'b0;
    #3;
    check("rst_level", 32'(if1.pad_level), 32'd0);
    check("rst_done", 32'(if1.decay_done), 32'd0);
    check("rst_last", 32'(if1.last_decay), 32'd0);
    check("rst_last_sat", 32'(if2.last_decay), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Untouched charge/decay.
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1; if1.touch_in = 1'b0;
    step(3);
    check("u_chg_c3", 32'(if1.pad_level), 32'd0);
    step(1);
    check("u_chg_c4", 32'(if1.pad_level), 32'd1);
    step(6);
    if1.pad_oe = 1'b0; d0 = done1;
    step(20);
    check("u_r19_lvl", 32'(if1.pad_level), 32'd1);
    check("u_r19_done", 32'(if1.decay_done), 32'd0);
    step(1);
    check("u_end_lvl", 32'(if1.pad_level), 32'd0);
    check("u_end_done", 32'(if1.decay_done), 32'd1);
    check("u_last", 32'(if1.last_decay), 32'd20);
    step(1);
    check("u_pulse_one", 32'(if1.decay_done), 32'd0);
    check("u_done_cnt", 32'(done1 - d0), 32'd1);

    // Touched release, touch toggled mid-decay.
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(10);
    if1.touch_in = 1'b1; if1.pad_oe = 1'b0;
    step(1);
    if1.touch_in = 1'b0;
    step(29);
    if1.touch_in = 1'b1;
    step(30);
    check("t_r59_lvl", 32'(if1.pad_level), 32'd1);
    step(1);
    check("t_end_lvl", 32'(if1.pad_level), 32'd0);
    check("t_end_done", 32'(if1.decay_done), 32'd1);
    check("t_last", 32'(if1.last_decay), 32'd60);
    step(1);
    if1.touch_in = 1'b0;

    // Partial charge then release.
    d0 = done1;
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(2);
    check("p_chg_lvl", 32'(if1.pad_level), 32'd0);
    if1.pad_oe = 1'b0;
    step(6);
    check("p_rel_lvl", 32'(if1.pad_level), 32'd0);
    check("p_no_done", 32'(done1 - d0), 32'd0);

    // Abort decay on cycle 10 with forced discharge.
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(10);
    if1.pad_oe = 1'b0;
    step(10);
    check("ad_r9_lvl", 32'(if1.pad_level), 32'd1);
    d0 = done1;
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b0;
    step(1);
    check("ad_lvl", 32'(if1.pad_level), 32'd0);
    if1.pad_oe = 1'b0;
    step(25);
    check("ad_no_done", 32'(done1 - d0), 32'd0);
    check("ad_last", 32'(if1.last_decay), 32'd60);

    // Abort decay by re-driving high: pad stays charged, then a fresh decay.
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(3);
    check("ar_chg_c3", 32'(if1.pad_level), 32'd0);
    step(1);
    check("ar_chg_c4", 32'(if1.pad_level), 32'd1);
    step(6);
    if1.pad_oe = 1'b0;
    step(10);
    d0 = done1;
    if1.pad_oe = 1'b1;
    step(1);
    check("ar_lvl", 32'(if1.pad_level), 32'd1);
    step(30);
    check("ar_hold_lvl", 32'(if1.pad_level), 32'd1);
    check("ar_no_done", 32'(done1 - d0), 32'd0);
    check("ar_last", 32'(if1.last_decay), 32'd60);
    if1.pad_oe = 1'b0;
    step(20);
    check("ar_r19_lvl", 32'(if1.pad_level), 32'd1);
    step(1);
    check("ar_end_lvl", 32'(if1.pad_level), 32'd0);
    check("ar_end_done", 32'(if1.decay_done), 32'd1);
    check("ar_last2", 32'(if1.last_decay), 32'd20);
    step(1);

    // Asynchronous reset in the middle of a decay.
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(10);
    if1.pad_oe = 1'b0;
    step(6);
    d0 = done1;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async_lvl", 32'(if1.pad_level), 32'd0);
    check("ar_async_done", 32'(if1.decay_done), 32'd0);
    check("ar_async_last", 32'(if1.last_decay), 32'd0);
    step(2);
    check("ar_held_lvl", 32'(if1.pad_level), 32'd0);
    rst_n = 1'b1;
    step(5);
    check("ar_post_no_done", 32'(done1 - d0), 32'd0);
    check("ar_post_lvl", 32'(if1.pad_level), 32'd0);
    if1.pad_oe = 1'b1; if1.pad_drive = 1'b1;
    step(3);
    check("rs_chg_c3", 32'(if1.pad_level), 32'd0);
    step(1);
    check("rs_chg_c4", 32'(if1.pad_level), 32'd1);
    step(2);
    if1.pad_oe = 1'b0;
    step(20);
    check("rs_r19_lvl", 32'(if1.pad_level), 32'd1);
    step(1);
    check("rs_end_lvl", 32'(if1.pad_level), 32'd0);
    check("rs_end_done", 32'(if1.decay_done), 32'd1);
    check("rs_last", 32'(if1.last_decay), 32'd20);

    // Saturating instance: 40+40 clips to 63 in 6 bits.
    d0 = done2;
    if2.pad_oe = 1'b1; if2.pad_drive = 1'b1;
    step(4);
    check("s_chg_c4", 32'(if2.pad_level), 32'd1);
    step(2);
    if2.touch_in = 1'b1; if2.pad_oe = 1'b0;
    step(63);
    check("s_r62_lvl", 32'(if2.pad_level), 32'd1);
    step(1);
    check("s_end_lvl", 32'(if2.pad_level), 32'd0);
    check("s_end_done", 32'(if2.decay_done), 32'd1);
    check("s_last", 32'(if2.last_decay), 32'd63);
    step(1);
    check("s_pulse_one", 32'(if2.decay_done), 32'd0);
    check("s_done_cnt", 32'(done2 - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
